// File: rtl/test_status_monitor.sv
// test_status_monitor
// Watches the execute-stage ALU report stream, tallies PASS/FAIL events,
// latches the reported values and stops the run on DONE, FAIL (optional)
// or a no-progress watchdog timeout. All outputs come straight from registers.
module test_status_monitor #(
  parameter int COUNT_WIDTH    = 16,
  parameter int WDOG_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit STOP_ON_FAIL   = 1'b1
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Valid,
  input  logic                   i_Advance,
  input  logic                   i_Flush,
  input  logic [1:0]             i_Pass_Done_Change,
  input  logic [15:0]            i_Pass_Done_Value,
  output logic [1:0]             o_State,
  output logic                   o_Halt,
  output logic                   o_End_Pulse,
  output logic [COUNT_WIDTH-1:0] o_Pass_Count,
  output logic [COUNT_WIDTH-1:0] o_Fail_Count,
  output logic [15:0]            o_Last_Pass_Value,
  output logic [15:0]            o_First_Fail_Value,
  output logic [15:0]            o_Done_Value,
  output logic                   o_Any_Fail
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_FAILED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [1:0] CODE_PASS = 2'd1;
  localparam logic [1:0] CODE_FAIL = 2'd2;
  localparam logic [1:0] CODE_DONE = 2'd3;

  // Counter value seen on the last idle cycle before the timeout fires.
  localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

`ifndef SYNTHESIS
  if (64'(TIMEOUT_CYCLES) > ((64'd1 << WDOG_WIDTH) - 64'd1)) begin : g_timeout_range
    $error("test_status_monitor: TIMEOUT_CYCLES does not fit in WDOG_WIDTH bits");
  end
`endif

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] pass_count_reg, pass_count_next;
  logic [COUNT_WIDTH-1:0] fail_count_reg, fail_count_next;
  logic [15:0]            last_pass_reg, last_pass_next;
  logic [15:0]            first_fail_reg, first_fail_next;
  logic [15:0]            done_value_reg, done_value_next;
  logic                   any_fail_reg, any_fail_next;
  logic                   end_pulse_reg, end_pulse_next;
  logic [WDOG_WIDTH-1:0]  wdog_reg, wdog_next;
  logic                   qualified;

  // A stalled op is only counted on the cycle it actually advances.
  assign qualified = i_Valid & i_Advance & ~i_Flush;

  // Next-state and bookkeeping; terminal states hold everything frozen.
  always_comb begin
    state_next      = state_reg;
    pass_count_next = pass_count_reg;
    fail_count_next = fail_count_reg;
    last_pass_next  = last_pass_reg;
    first_fail_next = first_fail_reg;
    done_value_next = done_value_reg;
    any_fail_next   = any_fail_reg;
    wdog_next       = wdog_reg;
    end_pulse_next  = 1'b0;

    if (state_reg == ST_RUN) begin
      if (qualified) begin
        case (i_Pass_Done_Change)
          CODE_PASS: begin
            if (pass_count_reg != {COUNT_WIDTH{1'b1}})
              pass_count_next = pass_count_reg + COUNT_WIDTH'(1);
            last_pass_next = i_Pass_Done_Value;
          end
          CODE_FAIL: begin
            if (fail_count_reg != {COUNT_WIDTH{1'b1}})
              fail_count_next = fail_count_reg + COUNT_WIDTH'(1);
            if (!any_fail_reg) begin
              first_fail_next = i_Pass_Done_Value;
              any_fail_next   = 1'b1;
            end
            if (STOP_ON_FAIL)
              state_next = ST_FAILED;
          end
          CODE_DONE: begin
            done_value_next = i_Pass_Done_Value;
            state_next      = ST_DONE;
          end
          default: ;
        endcase
      end

      // Any qualified op counts as progress, reported or not.
      if (TIMEOUT_CYCLES != 0) begin
        if (qualified)
          wdog_next = '0;
        else if (wdog_reg == WDOG_LIMIT)
          state_next = ST_TIMEOUT;
        else
          wdog_next = wdog_reg + WDOG_WIDTH'(1);
      end

      end_pulse_next = (state_next != ST_RUN);
    end
  end

  // State and data registers; reset beats any event in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg      <= ST_RUN;
      pass_count_reg <= '0;
      fail_count_reg <= '0;
      last_pass_reg  <= '0;
      first_fail_reg <= '0;
      done_value_reg <= '0;
      any_fail_reg   <= 1'b0;
      end_pulse_reg  <= 1'b0;
      wdog_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      pass_count_reg <= pass_count_next;
      fail_count_reg <= fail_count_next;
      last_pass_reg  <= last_pass_next;
      first_fail_reg <= first_fail_next;
      done_value_reg <= done_value_next;
      any_fail_reg   <= any_fail_next;
      end_pulse_reg  <= end_pulse_next;
      wdog_reg       <= wdog_next;
    end
  end

`ifndef SYNTHESIS
  // One summary line per terminated run, printed while the end pulse is high.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && end_pulse_reg) begin
      $display("test_status_monitor: end state=%0d pass=%0d fail=%0d value=%h",
               state_reg, pass_count_reg, fail_count_reg,
               (state_reg == ST_DONE)   ? done_value_reg :
               (state_reg == ST_FAILED) ? first_fail_reg : last_pass_reg);
    end
  end
`endif

  assign o_State            = state_reg;
  assign o_Halt             = (state_reg != ST_RUN);
  assign o_End_Pulse        = end_pulse_reg;
  assign o_Pass_Count       = pass_count_reg;
  assign o_Fail_Count       = fail_count_reg;
  assign o_Last_Pass_Value  = last_pass_reg;
  assign o_First_Fail_Value = first_fail_reg;
  assign o_Done_Value       = done_value_reg;
  assign o_Any_Fail         = any_fail_reg;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: three instances with different parameters
// share one stimulus stream; a behavioural model predicts every output each
// cycle into a scoreboard queue, plus explicit end-of-scenario checks.
module tb_test_status_monitor;

  localparam int NI = 3;
  // instance 0: stop on fail; instance 1: continue on fail; instance 2: tiny
  localparam int CW  [NI] = '{16, 16, 2};
  localparam int TMO [NI] = '{1000, 1000, 8};
  localparam int SOF [NI] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, advance = 1'b0, flush = 1'b0;
  logic [1:0]  change = 2'd0;
  logic [15:0] value = 16'h0;

  always #5 clk = ~clk;

  logic [1:0]  a_state, b_state, c_state;
  logic        a_halt, b_halt, c_halt, a_pulse, b_pulse, c_pulse;
  logic        a_any, b_any, c_any;
  logic [15:0] a_pass, b_pass, a_fail, b_fail;
  logic [1:0]  c_pass, c_fail;
  logic [15:0] a_last, b_last, c_last, a_first, b_first, c_first;
  logic [15:0] a_done, b_done, c_done;

  test_status_monitor #(.COUNT_WIDTH(16), .WDOG_WIDTH(24), .TIMEOUT_CYCLES(1000), .STOP_ON_FAIL(1'b1)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(valid), .i_Advance(advance), .i_Flush(flush),
    .i_Pass_Done_Change(change), .i_Pass_Done_Value(value),
    .o_State(a_state), .o_Halt(a_halt), .o_End_Pulse(a_pulse),
    .o_Pass_Count(a_pass), .o_Fail_Count(a_fail), .o_Last_Pass_Value(a_last),
    .o_First_Fail_Value(a_first), .o_Done_Value(a_done), .o_Any_Fail(a_any));

  test_status_monitor #(.COUNT_WIDTH(16), .WDOG_WIDTH(24), .TIMEOUT_CYCLES(1000), .STOP_ON_FAIL(1'b0)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(valid), .i_Advance(advance), .i_Flush(flush),
    .i_Pass_Done_Change(change), .i_Pass_Done_Value(value),
    .o_State(b_state), .o_Halt(b_halt), .o_End_Pulse(b_pulse),
    .o_Pass_Count(b_pass), .o_Fail_Count(b_fail), .o_Last_Pass_Value(b_last),
    .o_First_Fail_Value(b_first), .o_Done_Value(b_done), .o_Any_Fail(b_any));

  test_status_monitor #(.COUNT_WIDTH(2), .WDOG_WIDTH(8), .TIMEOUT_CYCLES(8), .STOP_ON_FAIL(1'b1)) dut_c (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(valid), .i_Advance(advance), .i_Flush(flush),
    .i_Pass_Done_Change(change), .i_Pass_Done_Value(value),
    .o_State(c_state), .o_Halt(c_halt), .o_End_Pulse(c_pulse),
    .o_Pass_Count(c_pass), .o_Fail_Count(c_fail), .o_Last_Pass_Value(c_last),
    .o_First_Fail_Value(c_first), .o_Done_Value(c_done), .o_Any_Fail(c_any));

  typedef struct {
    int state;
    int pass_c;
    int fail_c;
    int last_pass;
    int first_fail;
    int done_v;
    int any_fail;
    int end_pulse;
    int idle;
  } mdl_t;

  mdl_t mdl [NI];
  mdl_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural prediction of one clock edge for instance k.
  function automatic mdl_t model_step(input mdl_t s, input int k, input logic r,
                                      input logic v, input logic a, input logic f,
                                      input logic [1:0] c, input logic [15:0] d);
    mdl_t n;
    bit   q;
    int   maxc;
    n = s;
    n.end_pulse = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (s.state != 0) return n;
    q = v && a && !f;
    maxc = (1 << CW[k]) - 1;
    if (q && c == 2'd1) begin
      if (n.pass_c < maxc) n.pass_c++;
      n.last_pass = int'(d);
    end else if (q && c == 2'd2) begin
      if (n.fail_c < maxc) n.fail_c++;
      if (n.any_fail == 0) n.first_fail = int'(d);
      n.any_fail = 1;
      if (SOF[k] != 0) n.state = 2;
    end else if (q && c == 2'd3) begin
      n.done_v = int'(d);
      n.state = 1;
    end
    if (TMO[k] != 0) begin
      if (q) n.idle = 0;
      else begin
        n.idle++;
        if (n.idle == TMO[k]) n.state = 3;
      end
    end
    if (n.state != 0) n.end_pulse = 1;
    return n;
  endfunction

  task automatic compare_inst(input int k, input mdl_t e);
    logic [31:0] st, pc, fc, lp, ff, dv, af, ep, hl;
    case (k)
      0: begin st = 32'(a_state); pc = 32'(a_pass); fc = 32'(a_fail); lp = 32'(a_last);
               ff = 32'(a_first); dv = 32'(a_done); af = 32'(a_any); ep = 32'(a_pulse); hl = 32'(a_halt); end
      1: begin st = 32'(b_state); pc = 32'(b_pass); fc = 32'(b_fail); lp = 32'(b_last);
               ff = 32'(b_first); dv = 32'(b_done); af = 32'(b_any); ep = 32'(b_pulse); hl = 32'(b_halt); end
      default: begin st = 32'(c_state); pc = 32'(c_pass); fc = 32'(c_fail); lp = 32'(c_last);
               ff = 32'(c_first); dv = 32'(c_done); af = 32'(c_any); ep = 32'(c_pulse); hl = 32'(c_halt); end
    endcase
    check($sformatf("sb%0d_state", k), st, 32'(e.state));
    check($sformatf("sb%0d_halt", k), hl, 32'(e.state != 0));
    check($sformatf("sb%0d_end_pulse", k), ep, 32'(e.end_pulse));
    check($sformatf("sb%0d_pass_count", k), pc, 32'(e.pass_c));
    check($sformatf("sb%0d_fail_count", k), fc, 32'(e.fail_c));
    check($sformatf("sb%0d_last_pass", k), lp, 32'(e.last_pass));
    check($sformatf("sb%0d_first_fail", k), ff, 32'(e.first_fail));
    check($sformatf("sb%0d_done_value", k), dv, 32'(e.done_v));
    check($sformatf("sb%0d_any_fail", k), af, 32'(e.any_fail));
  endtask

  // Drive one cycle of stimulus, predict, clock, then compare the prediction.
  task automatic cycle(input logic r, input logic v, input logic a, input logic f,
                       input logic [1:0] c, input logic [15:0] d);
    mdl_t e;
    rst = r; valid = v; advance = a; flush = f; change = c; value = d;
    for (int k = 0; k < NI; k++) begin
      mdl[k] = model_step(mdl[k], k, r, v, a, f, c, d);
      sb_q.push_back(mdl[k]);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (sb_q.size() == 0) begin
        check("sb_queue_empty", 32'(sb_q.size()), 32'(1));
      end else begin
        e = sb_q.pop_front();
        compare_inst(k, e);
      end
    end
    $display("cyc %0d rst=%0b v=%0b adv=%0b fl=%0b code=%0d val=%h -> state a/b/c=%0d/%0d/%0d",
             cyc, r, v, a, f, c, d, a_state, b_state, c_state);
  endtask

  task automatic op(input logic [1:0] c, input logic [15:0] d);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, c, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) mdl[k] = '{default: 0};

    // 1: three passes then DONE
    do_reset();
    check("t1_reset_state", 32'(a_state), 32'd0);
    check("t1_reset_halt", 32'(a_halt), 32'd0);
    op(2'd1, 16'h0001); op(2'd1, 16'h0002); op(2'd1, 16'h0003);
    op(2'd3, 16'h00FF);
    check("t1_end_pulse_on", 32'(a_pulse), 32'd1);
    idle(1);
    check("t1_end_pulse_off", 32'(a_pulse), 32'd0);
    check("t1_pass_count", 32'(a_pass), 32'd3);
    check("t1_last_pass", 32'(a_last), 32'h0003);
    check("t1_state", 32'(a_state), 32'd1);
    check("t1_done_value", 32'(a_done), 32'h00FF);
    check("t1_halt", 32'(a_halt), 32'd1);
    check("t1_any_fail", 32'(a_any), 32'd0);

    // 2: stalled PASS counts once, flushed PASS not at all
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0010);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0010);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0020);
    idle(1);
    check("t2_pass_count", 32'(a_pass), 32'd1);
    check("t2_last_pass", 32'(a_last), 32'h0010);

    // 3/4: FAIL handling with and without stop-on-fail
    do_reset();
    op(2'd2, 16'h0BAD); op(2'd1, 16'h0005); op(2'd3, 16'h0077);
    check("t3_state", 32'(a_state), 32'd2);
    check("t3_fail_count", 32'(a_fail), 32'd1);
    check("t3_first_fail", 32'(a_first), 32'h0BAD);
    check("t3_pass_count", 32'(a_pass), 32'd0);
    check("t3_done_ignored", 32'(a_done), 32'h0000);
    do_reset();
    op(2'd2, 16'h0001); op(2'd2, 16'h0002); op(2'd3, 16'h0000);
    check("t4_fail_count", 32'(b_fail), 32'd2);
    check("t4_first_fail", 32'(b_first), 32'h0001);
    check("t4_any_fail", 32'(b_any), 32'd1);
    check("t4_state", 32'(b_state), 32'd1);

    // 5: watchdog on the TIMEOUT_CYCLES=8 instance
    do_reset();
    idle(7);
    op(2'd0, 16'h1234);
    idle(7);
    check("t5_still_run", 32'(c_state), 32'd0);
    idle(1);
    check("t5_timeout", 32'(c_state), 32'd3);
    check("t5_pulse_on", 32'(c_pulse), 32'd1);
    idle(1);
    check("t5_pulse_off", 32'(c_pulse), 32'd0);

    // 6: saturation on COUNT_WIDTH=2, then reset beats a PASS
    do_reset();
    for (int i = 0; i < 5; i++) op(2'd1, 16'(i + 1));
    check("t6_saturated", 32'(c_pass), 32'd3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 16'h00AA);
    check("t6_reset_pass", 32'(c_pass), 32'd0);
    check("t6_reset_state", 32'(c_state), 32'd0);
    check("t6_reset_last", 32'(c_last), 32'd0);
    check("t6_reset_a_pass", 32'(a_pass), 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
